systolic_array_tile: RTL and testbench

- Parametrised output-stationary ROWS x COLS systolic tile that computes C = A x B for one tile. Accumulations are signed and the inner dimension k_len is set per job.
- Generalises the fixed square PE array and drain-channel pair: non-square shape, built-in input skewing, a job-control FSM, and a row-wise drain with valid/ready backpressure.
- Sits between the operand fetch unit and the result writeback.

---
 rtl/systolic_array_tile.sv | 242 ++++++++++++++++++++++++
 tb/tb_systolic_array_tile.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/systolic_array_tile.sv
// Output-stationary ROWS x COLS systolic tile: skews operand beats, accumulates C = A x B per job,
// then drains C row by row over valid/ready. Define SA_ACC_SATURATE_EN for saturating accumulators.
module systolic_array_tile #(
    parameter int unsigned ROWS   = 4,
    parameter int unsigned COLS   = 4,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned ACC_W  = 32,
    parameter int unsigned MAX_K  = 256,
    parameter int unsigned K_W    = $clog2(MAX_K + 1),
    localparam int unsigned ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    start_i,
    input  logic [K_W-1:0]          k_len_i,
    output logic                    busy_o,
    input  logic                    op_valid_i,
    output logic                    op_ready_o,
    input  logic [ROWS*DATA_W-1:0]  a_i,
    input  logic [COLS*DATA_W-1:0]  b_i,
    output logic                    c_valid_o,
    input  logic                    c_ready_i,
    output logic [COLS*ACC_W-1:0]   c_o,
    output logic [ROW_W-1:0]        c_row_o,
    output logic                    c_last_o,
    output logic                    done_o
);

    localparam int unsigned PROD_W = 2 * DATA_W;
    localparam int unsigned SUM_W  = ACC_W + 1;
    localparam int unsigned CNT_W  = $clog2(MAX_K + ROWS + COLS);
    localparam logic [CNT_W-1:0] FLUSH_LAST = CNT_W'(ROWS + COLS - 2);
    localparam logic [ROW_W-1:0] LAST_ROW   = ROW_W'(ROWS - 1);

    typedef enum logic [1:0] {StIdle, StFeed, StFlush, StDrain} state_t;

    state_t             r_state;
    logic [K_W-1:0]     r_klen;
    logic [CNT_W-1:0]   r_cnt;
    logic [ROW_W-1:0]   r_row;
    logic               r_op_ready;
    logic               r_busy;
    logic               r_c_valid;
    logic               r_done;

    logic               w_accept;
    logic               w_clr;
    logic               w_acc_en;
    logic [DATA_W-1:0]  w_a   [ROWS][COLS];
    logic [DATA_W-1:0]  w_b   [ROWS][COLS];
    logic [ACC_W-1:0]   w_acc [ROWS][COLS];
    logic [COLS*ACC_W-1:0] w_c;

    assign w_accept = r_op_ready && op_valid_i;
    assign w_clr    = (r_state == StIdle) && start_i;
    assign w_acc_en = (r_state == StFeed) || (r_state == StFlush);

    // Job control; all handshake/status outputs are registered here.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= StIdle;
            r_klen     <= '0;
            r_cnt      <= '0;
            r_row      <= '0;
            r_op_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_c_valid  <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            unique case (r_state)
                StIdle: begin
                    if (start_i) begin
                        r_busy <= 1'b1;
                        r_row  <= '0;
                        r_cnt  <= '0;
                        if (k_len_i != '0) begin
                            r_klen     <= k_len_i;
                            r_op_ready <= 1'b1;
                            r_state    <= StFeed;
                        end else begin
                            r_c_valid <= 1'b1;
                            r_state   <= StDrain;
                        end
                    end
                end
                StFeed: begin
                    if (w_accept) begin
                        if (r_cnt == CNT_W'(r_klen - 1'b1)) begin
                            r_cnt      <= '0;
                            r_op_ready <= 1'b0;
                            r_state    <= StFlush;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                end
                StFlush: begin
                    if (r_cnt == FLUSH_LAST) begin
                        r_c_valid <= 1'b1;
                        r_row     <= '0;
                        r_state   <= StDrain;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StDrain: begin
                    if (c_ready_i) begin
                        if (r_row == LAST_ROW) begin
                            r_c_valid <= 1'b0;
                            r_busy    <= 1'b0;
                            r_done    <= 1'b1;
                            r_state   <= StIdle;
                        end else begin
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    // A skew: row r sees its lane r cycles late; bubbles inject zeros.
    for (genvar r = 0; r < ROWS; r++) begin : g_a_skew
        logic [DATA_W-1:0] w_lane;
        assign w_lane = w_accept ? a_i[r*DATA_W +: DATA_W] : '0;
        if (r == 0) begin : g_direct
            assign w_a[r][0] = w_lane;
        end else begin : g_delay
            logic [DATA_W-1:0] r_dly [r];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < r; i++) r_dly[i] <= '0;
                end else begin
                    r_dly[0] <= w_lane;
                    for (int i = 1; i < r; i++) r_dly[i] <= r_dly[i-1];
                end
            end
            assign w_a[r][0] = r_dly[r-1];
        end
    end

    for (genvar c = 0; c < COLS; c++) begin : g_b_skew
        logic [DATA_W-1:0] w_lane;
        assign w_lane = w_accept ? b_i[c*DATA_W +: DATA_W] : '0;
        if (c == 0) begin : g_direct
            assign w_b[0][c] = w_lane;
        end else begin : g_delay
            logic [DATA_W-1:0] r_dly [c];
            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    for (int i = 0; i < c; i++) r_dly[i] <= '0;
                end else begin
                    r_dly[0] <= w_lane;
                    for (int i = 1; i < c; i++) r_dly[i] <= r_dly[i-1];
                end
            end
            assign w_b[0][c] = r_dly[c-1];
        end
    end

    for (genvar r = 0; r < ROWS; r++) begin : g_row
        for (genvar c = 0; c < COLS; c++) begin : g_col
            logic signed [DATA_W-1:0] w_a_s;
            logic signed [DATA_W-1:0] w_b_s;
            logic signed [PROD_W-1:0] w_prod;
            logic signed [ACC_W-1:0]  w_prod_ext;
            logic signed [ACC_W-1:0]  w_acc_nxt;
            logic signed [ACC_W-1:0]  r_acc;

            assign w_a_s      = w_a[r][c];
            assign w_b_s      = w_b[r][c];
            assign w_prod     = PROD_W'(w_a_s) * PROD_W'(w_b_s);
            assign w_prod_ext = ACC_W'(w_prod);

`ifdef SA_ACC_SATURATE_EN
            logic signed [SUM_W-1:0] w_sum;
            assign w_sum = SUM_W'(r_acc) + SUM_W'(w_prod_ext);
            // Top two sum bits disagree only on overflow; the extra bit gives the true sign.
            always_comb begin
                if (w_sum[ACC_W] != w_sum[ACC_W-1]) begin
                    w_acc_nxt = w_sum[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}}
                                             : {1'b0, {(ACC_W-1){1'b1}}};
                end else begin
                    w_acc_nxt = w_sum[ACC_W-1:0];
                end
            end
`else
            assign w_acc_nxt = r_acc + w_prod_ext;
`endif

            always_ff @(posedge clk_i or negedge rst_ni) begin
                if (!rst_ni) begin
                    r_acc <= '0;
                end else if (w_clr) begin
                    r_acc <= '0;
                end else if (w_acc_en) begin
                    r_acc <= w_acc_nxt;
                end
            end
            assign w_acc[r][c] = r_acc;

            if (c < COLS - 1) begin : g_pass_a
                logic [DATA_W-1:0] r_a;
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) r_a <= '0;
                    else         r_a <= w_a[r][c];
                end
                assign w_a[r][c+1] = r_a;
            end

            if (r < ROWS - 1) begin : g_pass_b
                logic [DATA_W-1:0] r_b;
                always_ff @(posedge clk_i or negedge rst_ni) begin
                    if (!rst_ni) r_b <= '0;
                    else         r_b <= w_b[r][c];
                end
                assign w_b[r+1][c] = r_b;
            end
        end
    end

    // Accumulators are frozen outside FEED/FLUSH, so the selected row is stable under stall.
    always_comb begin
        w_c = '0;
        for (int r = 0; r < ROWS; r++) begin
            if (r_row == ROW_W'(r)) begin
                for (int c = 0; c < COLS; c++) w_c[c*ACC_W +: ACC_W] = w_acc[r][c];
            end
        end
    end

    assign busy_o     = r_busy;
    assign op_ready_o = r_op_ready;
    assign c_valid_o  = r_c_valid;
    assign c_o        = w_c;
    assign c_row_o    = r_row;
    assign c_last_o   = r_c_valid && (r_row == LAST_ROW);
    assign done_o     = r_done;

endmodule

// File: tb/tb_systolic_array_tile.sv
// Bench for systolic_array_tile: a 4x4/ACC_W=32 tile and a 2x3/ACC_W=16 tile share stimulus,
// results are compared against a plain matrix-product reference model.
`timescale 1ns/1ps
module tb_systolic_array_tile;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;        // 0: 4x4 tile, 1: 2x3 tile
    logic        start, op_valid, c_ready;
    logic [8:0]  k_len;
    logic [31:0] a_bus, b_bus;

    logic         m_busy, m_op_ready, m_c_valid, m_c_last, m_done;
    logic [127:0] m_c;
    logic [1:0]   m_row;
    logic         s_busy, s_op_ready, s_c_valid, s_c_last, s_done;
    logic [47:0]  s_c;
    logic [0:0]   s_row;

    systolic_array_tile u_dut_m (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start && !sel), .k_len_i(k_len),
        .busy_o(m_busy), .op_valid_i(op_valid && !sel), .op_ready_o(m_op_ready),
        .a_i(a_bus), .b_i(b_bus), .c_valid_o(m_c_valid), .c_ready_i(c_ready && !sel),
        .c_o(m_c), .c_row_o(m_row), .c_last_o(m_c_last), .done_o(m_done)
    );

    systolic_array_tile #(.ROWS(2), .COLS(3), .ACC_W(16)) u_dut_s (
        .clk_i(clk), .rst_ni(rst_n), .start_i(start && sel), .k_len_i(k_len),
        .busy_o(s_busy), .op_valid_i(op_valid && sel), .op_ready_o(s_op_ready),
        .a_i(a_bus[15:0]), .b_i(b_bus[23:0]), .c_valid_o(s_c_valid), .c_ready_i(c_ready && sel),
        .c_o(s_c), .c_row_o(s_row), .c_last_o(s_c_last), .done_o(s_done)
    );

    logic       o_busy, o_op_ready, o_c_valid, o_c_last, o_done;
    logic [1:0] o_row;
    assign o_busy     = sel ? s_busy     : m_busy;
    assign o_op_ready = sel ? s_op_ready : m_op_ready;
    assign o_c_valid  = sel ? s_c_valid  : m_c_valid;
    assign o_c_last   = sel ? s_c_last   : m_c_last;
    assign o_done     = sel ? s_done     : m_done;
    assign o_row      = sel ? {1'b0, s_row} : m_row;

`ifdef SA_ACC_SATURATE_EN
    localparam bit SAT = 1'b1;
`else
    localparam bit SAT = 1'b0;
`endif

    int     A [4][256];
    int     B [256][4];
    longint E [4][4];
    int     n_vec = 0;
    int     n_err = 0;

    task automatic check_eq(input string tag, input longint obs, input longint exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic longint lane(input int c);
        if (sel) return longint'($signed(s_c[c*16 +: 16]));
        return longint'($signed(m_c[c*32 +: 32]));
    endfunction

    // One accumulate step: clamp to the signed w-bit range, or keep the low w bits.
    function automatic longint fit(input longint x, input int w);
        longint lo, hi;
        lo = -(longint'(1) <<< (w - 1));
        hi = (longint'(1) <<< (w - 1)) - 1;
        if (SAT) return (x < lo) ? lo : ((x > hi) ? hi : x);
        return (x <<< (64 - w)) >>> (64 - w);
    endfunction

    task automatic model(input int rows, input int cols, input int klen, input int w);
        longint acc;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                acc = 0;
                if (r < rows && c < cols)
                    for (int k = 0; k < klen; k++) acc = fit(acc + A[r][k] * B[k][c], w);
                E[r][c] = acc;
            end
        end
    endtask

    task automatic set_identity();
        for (int k = 0; k < 256; k++)
            for (int i = 0; i < 4; i++) begin
                A[i][k] = (i == k) ? 1 : 0;
                B[k][i] = 10 * k + i;
            end
    endtask

    task automatic set_random();
        for (int k = 0; k < 256; k++)
            for (int i = 0; i < 4; i++) begin
                A[i][k] = int'($urandom_range(0, 255)) - 128;
                B[k][i] = int'($urandom_range(0, 255)) - 128;
            end
    endtask

    task automatic check_zero(input string tag, input int cols);
        check_eq({tag, "_busy"}, o_busy, 0);
        check_eq({tag, "_op_ready"}, o_op_ready, 0);
        check_eq({tag, "_c_valid"}, o_c_valid, 0);
        check_eq({tag, "_done"}, o_done, 0);
        check_eq({tag, "_c_last"}, o_c_last, 0);
        check_eq({tag, "_c_row"}, o_row, 0);
        for (int c = 0; c < cols; c++) check_eq($sformatf("%s_c%0d", tag, c), lane(c), 0);
    endtask

    // vmode: 0 always valid, 1 toggling, 2 random. rmode: 0 always ready, 1 stall row 1, 2 random.
    task automatic run_job(input bit s, input int klen, input int vmode, input int rmode,
                           input bit pulse_start);
        int rows, cols, w, k, guard, n, row;
        bit v, rdy;
        rows = s ? 2 : 4;
        cols = s ? 3 : 4;
        w    = s ? 16 : 32;
        sel  = s;
        model(rows, cols, klen, w);
        @(posedge clk); #1;
        check_eq("idle_busy", o_busy, 0);
        start = 1'b1;
        k_len = 9'(klen);
        @(posedge clk); #1;
        start = 1'b0;
        k_len = 9'($urandom_range(0, 511));
        check_eq("busy_after_start", o_busy, 1);
        if (klen > 0) begin
            k = 0;
            guard = 0;
            while (k < klen && guard < 4 * klen + 20) begin
                guard++;
                rdy = o_op_ready;
                check_eq("op_ready_feed", rdy, 1);
                v = (vmode == 0) ? 1'b1 : ((vmode == 1) ? ((guard % 2) == 1)
                                                         : 1'($urandom_range(0, 1)));
                op_valid = v;
                for (int r = 0; r < 4; r++)
                    a_bus[r*8 +: 8] = (v && r < rows) ? 8'(A[r][k]) : 8'($urandom);
                for (int c = 0; c < 4; c++)
                    b_bus[c*8 +: 8] = (v && c < cols) ? 8'(B[k][c]) : 8'($urandom);
                start = pulse_start && (k == 1);
                if (start) k_len = 9'd0;
                @(posedge clk); #1;
                if (v && rdy) k++;
            end
            op_valid = 1'b0;
            start    = 1'b0;
            check_eq("beats_accepted", k, klen);
            check_eq("op_ready_flush", o_op_ready, 0);
            // Last beat taken in cycle T; first valid in cycle T+ROWS+COLS.
            n = 0;
            while (!o_c_valid && n < 64) begin
                @(posedge clk); #1;
                n++;
            end
            check_eq("first_valid_latency", n, rows + cols - 1);
        end else begin
            check_eq("op_ready_k0", o_op_ready, 0);
        end
        row = 0;
        guard = 0;
        n = 0;
        while (row < rows && guard < 200) begin
            guard++;
            check_eq("c_valid", o_c_valid, 1);
            check_eq("c_row", o_row, row);
            check_eq("c_last", o_c_last, (row == rows - 1) ? 1 : 0);
            check_eq("done_early", o_done, 0);
            for (int c = 0; c < cols; c++)
                check_eq($sformatf("c[%0d][%0d]", row, c), lane(c), E[row][c]);
            if (rmode == 1)      rdy = !(row == 1 && n < 3);
            else if (rmode == 2) rdy = ($urandom_range(0, 2) != 0);
            else                 rdy = 1'b1;
            if (row == 1 && !rdy) n++;
            c_ready = rdy;
            @(posedge clk); #1;
            if (rdy) row++;
        end
        c_ready = 1'b0;
        check_eq("rows_drained", row, rows);
        check_eq("valid_after_drain", o_c_valid, 0);
        check_eq("done_pulse", o_done, 1);
        check_eq("busy_after_drain", o_busy, 0);
        @(posedge clk); #1;
        check_eq("done_single", o_done, 0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n    = 1'b0;
        sel      = 1'b0;
        start    = 1'b0;
        op_valid = 1'b0;
        c_ready  = 1'b0;
        k_len    = '0;
        a_bus    = '0;
        b_bus    = '0;
        #3;
        check_zero("reset_m", 4);
        sel = 1'b1;
        #1;
        check_zero("reset_s", 3);
        sel = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        set_identity();
        run_job(1'b0, 4, 0, 0, 1'b0);
        run_job(1'b0, 4, 1, 1, 1'b0);

        for (int r = 0; r < 2; r++)
            for (int k = 0; k < 2; k++) A[r][k] = (r == 0) ? ((k == 0) ? -1 : 2)
                                                           : ((k == 0) ? 3 : -4);
        B[0][0] = 5;  B[0][1] = -6; B[0][2] = 7;
        B[1][0] = -8; B[1][1] = 9;  B[1][2] = -10;
        run_job(1'b1, 2, 0, 0, 1'b0);

        set_random();
        run_job(1'b0, 0, 0, 0, 1'b0);
        run_job(1'b1, 0, 0, 2, 1'b0);

        for (int k = 0; k < 256; k++)
            for (int i = 0; i < 4; i++) begin
                A[i][k] = 127;
                B[k][i] = 127;
            end
        run_job(1'b1, 256, 0, 0, 1'b0);

        set_identity();
        run_job(1'b0, 4, 0, 0, 1'b1);

        // Abort a job mid-FEED with an asynchronous reset.
        sel = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        k_len = 9'd6;
        @(posedge clk); #1;
        start    = 1'b0;
        op_valid = 1'b1;
        a_bus    = 32'h0304_0506;
        b_bus    = 32'h0708_090a;
        @(posedge clk); #1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midfeed_reset", 4);
        repeat (3) begin
            @(posedge clk); #1;
            check_eq("done_in_reset", o_done, 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check_eq("done_after_reset", o_done, 0);
        check_eq("busy_after_reset", o_busy, 0);
        run_job(1'b0, 4, 0, 0, 1'b0);

        for (int j = 0; j < 12; j++) begin
            set_random();
            run_job(1'(j % 2), int'($urandom_range(1, 24)), 2, 2, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
